// File: rtl/vertical_fir_if.sv
// Row-stream handshake bundle for the vertical FIR stage: 64-bit pixel rows in and out.
interface vertical_fir_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_row;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_row;
    logic        out_last;

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_row, out_last
    );

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_row, out_last
    );
endinterface

// File: rtl/vertical_fir_stage.sv
// 8-tap vertical interpolation filter over a block of NUM_ROWS+7 rows of 8 pixels.
// Produces NUM_ROWS output rows; phase selects full/quarter/half/three-quarter pel.
module vertical_fir_stage #(
    parameter int unsigned NUM_ROWS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  frac,
    output logic        busy,
    vertical_fir_if.slave pix
);

    localparam int unsigned PIX_W = 8;
    localparam int unsigned LANES = 8;
    localparam int unsigned ROW_W = PIX_W * LANES;
    localparam int unsigned TAPS  = 8;
    localparam int unsigned CNT_W = $clog2(NUM_ROWS + 7);

    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(6);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(NUM_ROWS + 6);

    localparam logic signed [15:0] COEF_A [TAPS] =
        '{-16'sd1, 16'sd4, -16'sd10, 16'sd58, 16'sd17, -16'sd5, 16'sd1, 16'sd0};
    localparam logic signed [15:0] COEF_B [TAPS] =
        '{-16'sd1, 16'sd4, -16'sd11, 16'sd40, 16'sd40, -16'sd11, 16'sd4, -16'sd1};
    localparam logic signed [15:0] COEF_C [TAPS] =
        '{16'sd0, 16'sd1, -16'sd5, 16'sd17, 16'sd58, -16'sd10, 16'sd4, -16'sd1};

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [1:0]           frac_q;
    logic [CNT_W-1:0]     row_cnt_q;
    logic [ROW_W-1:0]     window_q [TAPS];
    logic [ROW_W-1:0]     window_d [TAPS];
    logic [ROW_W-1:0]     filt_row;
    logic [ROW_W-1:0]     out_row_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic                 in_ready_c;
    logic                 accept;
    logic                 out_fire;
    logic signed [15:0]   acc;
    logic signed [15:0]   rnd;

    function automatic logic signed [15:0] coef(input logic [1:0] f, input logic [2:0] t);
        case (f)
            2'd1:    return COEF_A[t];
            2'd2:    return COEF_B[t];
            2'd3:    return COEF_C[t];
            default: return 16'sd0;
        endcase
    endfunction

    assign accept   = pix.in_valid && in_ready_c;
    assign out_fire = out_valid_q && pix.out_ready;

    // Window as it will look once the incoming row is shifted in at tap 7.
    always_comb begin
        for (int unsigned i = 0; i < TAPS - 1; i++) begin
            window_d[i] = window_q[i + 1];
        end
        window_d[TAPS-1] = pix.in_row;
    end

    // Per-column filter with rounding and clip; phase 0 passes tap 3 through.
    always_comb begin
        filt_row = '0;
        acc      = '0;
        rnd      = '0;
        for (int unsigned c = 0; c < LANES; c++) begin
            acc = '0;
            for (int unsigned t = 0; t < TAPS; t++) begin
                acc = acc + coef(frac_q, 3'(t)) * $signed({8'd0, window_d[t][PIX_W*c +: PIX_W]});
            end
            rnd = (acc + 16'sd32) >>> 6;
            if (frac_q == 2'd0) begin
                filt_row[PIX_W*c +: PIX_W] = window_d[3][PIX_W*c +: PIX_W];
            end else if (rnd < 16'sd0) begin
                filt_row[PIX_W*c +: PIX_W] = 8'd0;
            end else if (rnd > 16'sd255) begin
                filt_row[PIX_W*c +: PIX_W] = 8'd255;
            end else begin
                filt_row[PIX_W*c +: PIX_W] = rnd[7:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FILL;
            end
            FILL: begin
                in_ready_c = 1'b1;
                if (pix.in_valid && row_cnt_q == FILL_LAST) state_d = RUN;
            end
            RUN: begin
                in_ready_c = !out_valid_q || pix.out_ready;
                if (pix.in_valid && in_ready_c && row_cnt_q == RUN_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            frac_q      <= '0;
            row_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= '0;
            for (int unsigned i = 0; i < TAPS; i++) window_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                frac_q    <= frac;
                row_cnt_q <= '0;
            end
            if (accept) begin
                for (int unsigned i = 0; i < TAPS; i++) window_q[i] <= window_d[i];
                row_cnt_q <= row_cnt_q + CNT_W'(1);
            end
            // A fresh result overrides the clear when consumer and producer move together.
            if (accept && state_q == RUN) begin
                out_valid_q <= 1'b1;
                out_row_q   <= filt_row;
                out_last_q  <= (row_cnt_q == RUN_LAST);
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign pix.in_ready  = in_ready_c;
    assign pix.out_valid = out_valid_q;
    assign pix.out_row   = out_row_q;
    assign pix.out_last  = out_last_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_vertical_fir_stage.sv
// Directed bench for vertical_fir_stage: integer reference filter feeds an expected-output
// queue that a negedge monitor drains on every output transfer.
module tb_vertical_fir_stage;

    localparam int NR  = 8;
    localparam int NIN = NR + 7;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [1:0] frac  = 2'd0;
    logic       busy;

    vertical_fir_if ifc();

    vertical_fir_stage #(.NUM_ROWS(NR)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .frac  (frac),
        .busy  (busy),
        .pix   (ifc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] row;
        logic        last;
    } exp_t;

    exp_t        exp_q [$];
    logic [63:0] got_q [$];
    logic [63:0] saved_q [$];
    logic [63:0] blk [NIN];
    int          last_cnt;
    int          checks;
    int          errors;

    // Phase 0 expressed as a single 64 weight at tap 3 gives the identity after rounding.
    int ctab [4][8] = '{
        '{ 0, 0,   0, 64,  0,   0, 0,  0},
        '{-1, 4, -10, 58, 17,  -5, 1,  0},
        '{-1, 4, -11, 40, 40, -11, 4, -1},
        '{ 0, 1,  -5, 17, 58, -10, 4, -1}
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model(input int j, input int f);
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < 8; c++) begin
            int s;
            s = 0;
            for (int t = 0; t < 8; t++) s += ctab[f][t] * int'(blk[j-7+t][8*c +: 8]);
            s = (s + 32) >>> 6;
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            r[8*c +: 8] = 8'(s);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && ifc.out_valid && ifc.out_ready) begin : mon
            exp_t e;
            got_q.push_back(ifc.out_row);
            if (ifc.out_last) last_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_output observed=%h expected=none", ifc.out_row);
            end else begin
                e = exp_q.pop_front();
                chk("out_row", ifc.out_row, e.row);
                chk("out_last", 64'(ifc.out_last), 64'(e.last));
            end
        end
    end

    task automatic send_row(input logic [63:0] r);
        int n;
        n = 0;
        ifc.in_valid = 1'b1;
        ifc.in_row   = r;
        @(negedge clk);
        while (!ifc.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!ifc.in_ready) begin
            checks++;
            errors++;
            $error("FAIL in_ready_timeout observed=0 expected=1");
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (busy) begin
            checks++;
            errors++;
            $error("FAIL idle_timeout observed=busy expected=idle");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [1:0] f);
        wait_idle();
        start = 1'b1;
        frac  = f;
        @(posedge clk);
        #1;
        start = 1'b0;
        frac  = ~f;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic run_block(input logic [1:0] f, input int stall_after,
                             input int reset_after, input int poke_at);
        logic [63:0] held;
        got_q.delete();
        last_cnt = 0;
        start_block(f);
        for (int j = 0; j < NIN; j++) begin
            if (j == poke_at) begin
                start = 1'b1;
                frac  = f ^ 2'b01;
            end
            send_row(blk[j]);
            start = 1'b0;
            if (j >= 7) exp_q.push_back('{row: model(j, int'(f)), last: (j == NIN - 1)});
            if (j == 6) chk("no_out_in_fill", 64'(ifc.out_valid), 64'd0);
            if (j == 7) chk("first_out_latency", 64'(ifc.out_valid), 64'd1);
            if (j == stall_after) begin
                held          = ifc.out_row;
                ifc.out_ready = 1'b0;
                ifc.in_valid  = 1'b1;
                ifc.in_row    = blk[j+1];
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(ifc.in_ready), 64'd0);
                    chk("stall_out_row", ifc.out_row, held);
                    chk("stall_out_valid", 64'(ifc.out_valid), 64'd1);
                end
                @(posedge clk);
                #1;
                ifc.out_ready = 1'b1;
            end
            if (j == reset_after) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk("rst_pending_dropped", 64'(exp_q.size()), 64'd1);
                chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
                chk("rst_out_last", 64'(ifc.out_last), 64'd0);
                chk("rst_out_row", ifc.out_row, 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_in_ready", 64'(ifc.in_ready), 64'd0);
                exp_q.delete();
                return;
            end
        end
        wait_idle();
        chk("outputs_per_block", 64'(got_q.size()), 64'(NR));
        chk("out_last_count", 64'(last_cnt), 64'd1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        checks        = 0;
        errors        = 0;
        last_cnt      = 0;
        ifc.in_valid  = 1'b0;
        ifc.in_row    = '0;
        ifc.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("reset_out_last", 64'(ifc.out_last), 64'd0);
        chk("reset_out_row", ifc.out_row, 64'd0);
        chk("reset_in_ready", 64'(ifc.in_ready), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // Flat field of 0x64 at half-pel must come back unchanged.
        for (int j = 0; j < NIN; j++) blk[j] = {8{8'h64}};
        run_block(2'd2, -1, -1, -1);
        for (int k = 0; k < NR; k++) chk("flat_half", got_q[k], {8{8'h64}});

        // Step edge at half-pel: first output sits mid-step, later ones saturate.
        for (int j = 0; j < NIN; j++) blk[j] = (j < 4) ? 64'd0 : {8{8'hFF}};
        run_block(2'd2, -1, -1, -1);
        chk("step_row0", got_q[0], {8{8'h80}});
        for (int k = 4; k < NR; k++) chk("step_sat", got_q[k], {8{8'hFF}});

        // Only negative taps lit: sum below zero clips to 0.
        for (int j = 0; j < NIN; j++)
            blk[j] = (j == 0 || j == 2 || j == 5 || j == 7) ? {8{8'hFF}} : 64'd0;
        run_block(2'd2, -1, -1, -1);
        chk("neg_clip_row0", got_q[0], 64'd0);

        // Full-pel: output k equals input row k+3.
        for (int j = 0; j < NIN; j++) blk[j] = {8{8'(j)}};
        run_block(2'd0, -1, -1, -1);
        for (int k = 0; k < NR; k++) begin
            b = 8'(k + 3);
            chk("fullpel_row", got_q[k], {8{b}});
        end

        // Back-pressure: stalled run must match the unstalled run exactly.
        for (int j = 0; j < NIN; j++) blk[j] = {$urandom, $urandom};
        run_block(2'd1, 9, -1, -1);
        saved_q = got_q;
        run_block(2'd1, -1, -1, -1);
        for (int k = 0; k < NR; k++) chk("stall_vs_nostall", saved_q[k], got_q[k]);

        // Mid-block reset with a stray start in RUN, then a clean quarter-pel block.
        for (int j = 0; j < NIN; j++) blk[j] = {$urandom, $urandom};
        run_block(2'd3, -1, 9, 8);
        for (int j = 0; j < NIN; j++) blk[j] = {$urandom, $urandom};
        run_block(2'd1, -1, -1, 10);

        // Three-quarter phase on random data.
        for (int j = 0; j < NIN; j++) blk[j] = {$urandom, $urandom};
        run_block(2'd3, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vertical_fir_stage.md
VERTICAL_FIR_STAGE -- requirements
Module: vertical_fir_stage

Interface
REQ-001 Parameter: NUM_ROWS, 8, output rows per block; input rows per block = NUM_ROWS+7.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begins a block; sampled only in IDLE.
REQ-005 frac  input  2  vertical phase: 0 full-pel, 1 quarter (A), 2 half (B), 3 three-quarter (C); latched on accepted start.
REQ-006 in_valid  input  1  in_row valid.
REQ-007 in_ready  output  1  stage accepts in_row this cycle.
REQ-008 in_row  input  64  one row of 8 horizontally filtered pixels; pixel i at bits [8i+7:8i], unsigned.
REQ-009 out_valid  output  1  out_row valid.
REQ-010 out_ready  input  1  consumer accepts out_row.
REQ-011 out_row  output  64  8 vertically filtered pixels, same packing as in_row.
REQ-012 out_last  output  1  high with out_valid on final output row of block.
REQ-013 busy  output  1  high in any state except IDLE.

Function
REQ-014 Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
REQ-015 States IDLE, FILL, RUN, DRAIN.
- IDLE: in_ready=0; start -> FILL, frac latched, row counter cleared.
- FILL: in_ready=1; after 7 accepted rows -> RUN.
- RUN: in_ready = !out_valid || out_ready; when row NUM_ROWS+6 (zero-based) accepted -> DRAIN.
- DRAIN: in_ready=0; final output accepted -> IDLE.
REQ-016 start outside IDLE SHALL be ignored; frac changes outside IDLE SHALL have no effect.
REQ-017 Window: 8-row shift register, 64 bits per entry; each accepted row shifts in at tap 7, oldest row discarded from tap 0.
REQ-018 Each row accepted in RUN SHALL load out_row from the updated window (taps 0..7 = input rows k..k+7) and set out_valid the following cycle (latency 1 clock).
REQ-019 Coefficients, taps 0..7: A = -1,4,-10,58,17,-5,1,0; B = -1,4,-11,40,40,-11,4,-1; C = 0,1,-5,17,58,-10,4,-1.
REQ-020 Arithmetic per column: 16-bit signed sum of coef*pixel, then +32, arithmetic shift right 6, clip to 0..255.
REQ-021 frac=0: out_row = window tap 3 unmodified (output row k = input row k+3).
REQ-022 out_valid SHALL clear on output transfer unless a new row is accepted in the same cycle, in which case it stays high with new data.
REQ-023 While out_valid && !out_ready: out_row, out_last held stable; no window shift.
REQ-024 out_last SHALL be high exactly on output row NUM_ROWS-1 of the block.
REQ-025 Input rows beyond NUM_ROWS+7 per block are not accepted (in_ready=0 in DRAIN/IDLE).
REQ-026 A new start is accepted only from IDLE; back-to-back blocks need one IDLE cycle.

Reset
REQ-027 rst SHALL force IDLE, out_valid=0, out_last=0, out_row=0, in_ready=0, busy=0, window and counter cleared, frac register=0.
REQ-028 rst mid-block SHALL abandon the block; no output generated for pre-reset rows.
REQ-029 rst takes priority over start and all transfers in the same cycle.

Verification
REQ-030 All 15 rows = 0x64 each pixel, frac=2, out_ready=1 -> 8 outputs, every pixel 0x64, out_last on 8th, first out_valid one clock after row 7 accepted.
REQ-031 Rows 0-3 = 0x00, rows 4-14 = 0xFF, frac=2 -> output row 0 all pixels 0x80 (8160+32>>6=128), rows 4-7 all 0xFF.
REQ-032 frac=2, rows 0,2,5,7 = 0xFF, others 0x00 -> output row 0 all 0x00 (negative sum clipped); frac=0 with row r pixels = r -> output k pixels = k+3.
REQ-033 out_ready low 5 cycles during RUN -> out_row stable, in_ready=0, no rows lost; output sequence identical to no-stall run.
REQ-034 rst asserted after row 9 accepted, then new block with frac=1 -> no stale output, new block's 8 outputs correct, out_last once; start in RUN ignored.
